soc_bus_arb: RTL and testbench

Two-master bus arbiter and access sequencer for the SoC data bus. Shares the single address/write-data path in front of the SoC address decoder (data memory at 0x000000xx, I/O ports at 0x000008xx and 0x000009xx) between the MIPS core data port (master 0) and a DMA engine (master 1). Each transaction gets its own region-dependent wait states, a one-cycle write strobe and a registered read-data capture. Accesses outside the map are blocked and returned with an error.

---
 rtl/soc_bus_arb.sv | 202 ++++++++++++++++++++
 tb/tb_soc_bus_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arb.sv
// soc_bus_arb: two-master arbiter and access sequencer for the SoC data bus.
// Master 0 (core data port) and master 1 (DMA) share one address/write-data
// path to the address decoder. Each transaction is held on the bus for a
// region-dependent number of cycles. Writes strobe once, reads are captured
// at the last bus cycle, and unmapped addresses are answered with an error.
//
// Parameters:
//   MEM_WAIT  extra ACCESS cycles for data memory (0x000000xx), 0..15
//   IO_WAIT   extra ACCESS cycles for I/O (0x000008xx, 0x000009xx), 0..15
//   FAIR      1 = alternate grants on contention, 0 = master 0 always wins
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mX_req/we/addr/wdata            master X request, sampled in IDLE only
//   mX_ack/err/rdata                master X one-cycle completion, error, read data
//   bus_a/bus_we/bus_wd             address, write strobe, write data to slaves
//   bus_rd                          read data from the decoder read mux
//   bus_busy                        high while a transaction is in progress

module soc_bus_arb #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 0,
    parameter int unsigned FAIR     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_a,
    output logic        bus_we,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd,
    output logic        bus_busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 err_pend_q, err_pend_d;
    logic                 last_grant_q, last_grant_d;
    logic [AW-1:0]        bus_a_q, bus_a_d;
    logic [DW-1:0]        bus_wd_q, bus_wd_d;
    logic                 bus_we_q, bus_we_d;
    logic                 busy_q, busy_d;
    logic [1:0]           ack_q, ack_d;
    logic [1:0]           err_q, err_d;
    logic [1:0][DW-1:0]   rdata_q, rdata_d;

    logic                 win_sel;
    logic                 win_we;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_wdata;
    logic                 is_mem;
    logic                 is_io;

    // Winner selection and region decode of the winning address.
    always_comb begin
        win_sel = 1'b0;
        if (m1_req && !m0_req) begin
            win_sel = 1'b1;
        end else if (m0_req && m1_req && (FAIR != 0) && !last_grant_q) begin
            // Contention under fair mode: m0 had the last grant, so m1 goes.
            win_sel = 1'b1;
        end
        win_we    = win_sel ? m1_we    : m0_we;
        win_addr  = win_sel ? m1_addr  : m0_addr;
        win_wdata = win_sel ? m1_wdata : m0_wdata;
        is_mem    = (win_addr[31:8] == 24'h000000);
        is_io     = (win_addr[31:8] == 24'h000008) || (win_addr[31:8] == 24'h000009);
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            err_pend_q   <= 1'b0;
            last_grant_q <= 1'b1;
            bus_a_q      <= '0;
            bus_wd_q     <= '0;
            bus_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            err_pend_q   <= err_pend_d;
            last_grant_q <= last_grant_d;
            bus_a_q      <= bus_a_d;
            bus_wd_q     <= bus_wd_d;
            bus_we_q     <= bus_we_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state logic. Outputs are computed one cycle ahead so every port
    // comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        we_d         = we_q;
        err_pend_d   = err_pend_q;
        last_grant_d = last_grant_q;
        bus_a_d      = bus_a_q;
        bus_wd_d     = bus_wd_q;
        ack_d        = '0;
        err_d        = err_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    sel_d        = win_sel;
                    last_grant_d = win_sel;
                    we_d         = win_we;
                    if (is_mem || is_io) begin
                        cnt_d    = is_mem ? CW'(MEM_WAIT) : CW'(IO_WAIT);
                        bus_a_d  = win_addr;
                        bus_wd_d = win_wdata;
                        state_d  = ST_ACCESS;
                    end else begin
                        // Unmapped: never drive the bus, answer at once.
                        err_pend_d       = 1'b1;
                        ack_d[win_sel]   = 1'b1;
                        err_d[win_sel]   = 1'b1;
                        rdata_d[win_sel] = '0;
                        state_d          = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    bus_a_d        = '0;
                    bus_wd_d       = '0;
                    ack_d[sel_q]   = 1'b1;
                    err_d[sel_q]   = err_pend_q;
                    if (!we_q) begin
                        rdata_d[sel_q] = bus_rd;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                err_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write strobe only in the final ACCESS cycle (counter at zero).
        bus_we_d = (state_d == ST_ACCESS) && (cnt_d == '0) && we_d;
        busy_d   = (state_d != ST_IDLE);
    end

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign bus_a    = bus_a_q;
    assign bus_wd   = bus_wd_q;
    assign bus_we   = bus_we_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_soc_bus_arb.sv
// tb_soc_bus_arb: directed bench for soc_bus_arb. Two instances share the
// stimulus: dut_a (MEM_WAIT=1, IO_WAIT=0, FAIR=1) and dut_b (MEM_WAIT=3,
// IO_WAIT=0, FAIR=0).

module tb_soc_bus_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rd;

    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_bus_we, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_a, a_bus_wd;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_bus_we, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_a, b_bus_wd;

    int n_cmp = 0;
    int n_bad = 0;

    soc_bus_arb #(.MEM_WAIT(1), .IO_WAIT(0), .FAIR(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(a_m0_ack), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
        .m1_ack(a_m1_ack), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
        .bus_a(a_bus_a), .bus_we(a_bus_we), .bus_wd(a_bus_wd),
        .bus_rd(bus_rd), .bus_busy(a_busy)
    );

    soc_bus_arb #(.MEM_WAIT(3), .IO_WAIT(0), .FAIR(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .bus_a(b_bus_a), .bus_we(b_bus_we), .bus_wd(b_bus_wd),
        .bus_rd(bus_rd), .bus_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (n) tick();
    endtask

    int acks;
    int wes;
    int na, b0, b1, dual;
    int seq [4];
    int cyc [4];

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; bus_rd = '0;
        tick();
        tick();

        // Reset values
        check("rst m0_ack",  32'(a_m0_ack), 32'd0);
        check("rst m1_ack",  32'(a_m1_ack), 32'd0);
        check("rst bus_a",   a_bus_a, 32'd0);
        check("rst bus_we",  32'(a_bus_we), 32'd0);
        check("rst busy",    32'(a_busy), 32'd0);
        check("rst m0_rdata", a_m0_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // m1 I/O read, zero wait states
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0904; bus_rd = 32'h0000_005A;
        tick();
        check("io_rd bus_a",  a_bus_a, 32'h0000_0904);
        check("io_rd bus_we", 32'(a_bus_we), 32'd0);
        check("io_rd busy",   32'(a_busy), 32'd1);
        check("io_rd ack_early", 32'(a_m1_ack), 32'd0);
        m1_req = 1'b0; m1_addr = 32'h0;
        tick();
        check("io_rd m1_ack",   32'(a_m1_ack), 32'd1);
        check("io_rd m1_rdata", a_m1_rdata, 32'h0000_005A);
        check("io_rd m1_err",   32'(a_m1_err), 32'd0);
        check("io_rd m0_ack",   32'(a_m0_ack), 32'd0);
        check("io_rd bus_a_resp", a_bus_a, 32'd0);
        tick();
        check("io_rd ack_drop", 32'(a_m1_ack), 32'd0);
        check("io_rd rdata_hold", a_m1_rdata, 32'h0000_005A);
        settle(4);

        // m0 memory write; A has 1 wait state, B has 3
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF;
        tick();
        check("mwr bus_a_c1",  a_bus_a, 32'h0000_0010);
        check("mwr bus_wd_c1", a_bus_wd, 32'hDEAD_BEEF);
        check("mwr bus_we_c1", 32'(a_bus_we), 32'd0);
        m0_req = 1'b0; m0_wdata = 32'h0; m0_addr = 32'h0000_1000;
        tick();
        check("mwr bus_a_c2",  a_bus_a, 32'h0000_0010);
        check("mwr bus_we_c2", 32'(a_bus_we), 32'd1);
        check("mwr ack_c2",    32'(a_m0_ack), 32'd0);
        tick();
        check("mwr m0_ack",    32'(a_m0_ack), 32'd1);
        check("mwr m0_err",    32'(a_m0_err), 32'd0);
        check("mwr bus_we_resp", 32'(a_bus_we), 32'd0);
        check("mwr bus_a_resp",  a_bus_a, 32'd0);
        check("mwr b_we_c3",   32'(b_bus_we), 32'd0);
        tick();
        check("mwr b_we_c4",   32'(b_bus_we), 32'd1);
        check("mwr b_ack_c4",  32'(b_m0_ack), 32'd0);
        tick();
        check("mwr b_ack_c5",  32'(b_m0_ack), 32'd1);
        settle(4);

        // Reset in the middle of a write on B (MEM_WAIT=3)
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = 32'hCAFE_F00D;
        tick();
        m0_req = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst b_bus_a",  b_bus_a, 32'd0);
        check("arst b_bus_wd", b_bus_wd, 32'd0);
        check("arst b_bus_we", 32'(b_bus_we), 32'd0);
        check("arst a_bus_we", 32'(a_bus_we), 32'd0);
        check("arst b_busy",   32'(b_busy), 32'd0);
        check("arst a_m1_rdata", a_m1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        wes = 0;
        repeat (8) begin
            tick();
            acks += int'(a_m0_ack) + int'(b_m0_ack) + int'(a_m1_ack) + int'(b_m1_ack);
            wes  += int'(a_bus_we) + int'(b_bus_we);
        end
        check("arst no_ack", 32'(acks), 32'd0);
        check("arst no_we",  32'(wes), 32'd0);

        // m0 read after reset: ack on A at tick 3, on B at tick 5
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0024; bus_rd = 32'h1234_5678;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (t == 1) m0_req = 1'b0;
            check($sformatf("rd a_ack t%0d", t), 32'(a_m0_ack), (t == 3) ? 32'd1 : 32'd0);
            check($sformatf("rd b_ack t%0d", t), 32'(b_m0_ack), (t == 5) ? 32'd1 : 32'd0);
        end
        check("rd a_rdata", a_m0_rdata, 32'h1234_5678);
        check("rd b_rdata", b_m0_rdata, 32'h1234_5678);
        check("rd a_err",   32'(a_m0_err), 32'd0);
        settle(3);

        // Unmapped write: immediate error ack, bus untouched
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_1000; m0_wdata = 32'h0000_0055;
        bus_rd = 32'hFFFF_FFFF;
        tick();
        check("unm m0_ack",   32'(a_m0_ack), 32'd1);
        check("unm m0_err",   32'(a_m0_err), 32'd1);
        check("unm m0_rdata", a_m0_rdata, 32'd0);
        check("unm bus_a",    a_bus_a, 32'd0);
        check("unm bus_we",   32'(a_bus_we), 32'd0);
        check("unm busy",     32'(a_busy), 32'd1);
        check("unm b_ack",    32'(b_m0_ack), 32'd1);
        check("unm b_rdata",  b_m0_rdata, 32'd0);
        m0_req = 1'b0;
        tick();
        check("unm ack_drop", 32'(a_m0_ack), 32'd0);
        check("unm bus_a2",   a_bus_a, 32'd0);
        check("unm bus_we2",  32'(a_bus_we), 32'd0);
        check("unm busy2",    32'(a_busy), 32'd0);
        settle(3);

        // Contention after reset: A alternates starting with m0, B starves m1
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0020;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0800;
        bus_rd = 32'h0000_0077;
        na = 0; b0 = 0; b1 = 0; dual = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = -1;
            cyc[i] = -1;
        end
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (a_m0_ack && a_m1_ack) dual++;
            if (a_m0_ack) begin
                if (na < 4) begin seq[na] = 0; cyc[na] = c; end
                na++;
            end
            if (a_m1_ack) begin
                if (na < 4) begin seq[na] = 1; cyc[na] = c; end
                na++;
            end
            b0 += int'(b_m0_ack);
            b1 += int'(b_m1_ack);
        end
        check("ctn grant0", 32'(seq[0]), 32'd0);
        check("ctn grant1", 32'(seq[1]), 32'd1);
        check("ctn grant2", 32'(seq[2]), 32'd0);
        check("ctn grant3", 32'(seq[3]), 32'd1);
        check("ctn first_ack_cycle", 32'(cyc[0]), 32'd3);
        check("ctn gap01", 32'(cyc[1] - cyc[0]), 32'd3);
        check("ctn gap12", 32'(cyc[2] - cyc[1]), 32'd4);
        check("ctn gap23", 32'(cyc[3] - cyc[2]), 32'd3);
        check("ctn a_acks", 32'(na), 32'd8);
        check("ctn dual_ack", 32'(dual), 32'd0);
        check("ctn a_m1_rdata", a_m1_rdata, 32'h0000_0077);
        check("ctn b_m0_acks", 32'(b0), 32'd5);
        check("ctn b_m1_acks", 32'(b1), 32'd0);
        settle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
